// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage core.
// Holds the write-back selector encoding, the elastic-stage state encoding
// and the core-width stage payload struct reused by other stage registers.
package pipe_pkg;

    localparam int unsigned CORE_DATA_W     = 32;
    localparam int unsigned CORE_REG_ADDR_W = 5;
    localparam int unsigned CORE_WB_SEL_W   = 2;

    // Write-back source encoding; 2'b11 is reserved and selects zero.
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_NPC = 2'b10;

    // Occupancy of a two-entry elastic stage (main slot + skid slot).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Core-width payload carried between MEM and WB.
    typedef struct packed {
        logic [CORE_DATA_W-1:0]     npc;
        logic [CORE_DATA_W-1:0]     alu_c;
        logic [CORE_DATA_W-1:0]     mem_data;
        logic [CORE_REG_ADDR_W-1:0] wr_num;
        logic                       wr_en;
        logic [CORE_WB_SEL_W-1:0]   wb_sel;
    } wb_slot_t;

endpackage

// File: rtl/wb_sel_mux.sv
// Combinational write-back value selector.
// Ports: sel (source select), npc / alu_c / mem_data (candidates),
//        wb_data (selected value, zero for the reserved encoding).
module wb_sel_mux
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WB_SEL_W = 2
) (
    input  logic [WB_SEL_W-1:0] sel,
    input  logic [DATA_W-1:0]   npc,
    input  logic [DATA_W-1:0]   alu_c,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W-1:0]   wb_data
);

    always_comb begin
        wb_data = '0;
        case (sel)
            WB_SEL_W'(WB_SEL_ALU): wb_data = alu_c;
            WB_SEL_W'(WB_SEL_MEM): wb_data = mem_data;
            WB_SEL_W'(WB_SEL_NPC): wb_data = npc;
            default:               wb_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB pipeline stage with a one-entry skid buffer.
// Ports:
//   clock, reset (sync, active-high), flush (sync squash of held entries)
//   in_valid/in_ready + in_* payload   : from the MEM stage
//   out_valid/out_ready + out_*        : to the register-file write port
//   fwd_valid/fwd_num/fwd_data         : forwarding tap for the hazard unit
//   stall_cnt                          : saturating back-pressure cycle count
module mem_wb_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WB_SEL_W   = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_npc,
    input  logic [DATA_W-1:0]     in_alu_c,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_wr_num,
    input  logic                  in_wr_en,
    input  logic [WB_SEL_W-1:0]   in_wb_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_wr_num,
    output logic                  out_wr_en,
    output logic [DATA_W-1:0]     out_wb_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_num,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Width-parametrised form of pipe_pkg::wb_slot_t.
    typedef struct packed {
        logic [DATA_W-1:0]     npc;
        logic [DATA_W-1:0]     alu_c;
        logic [DATA_W-1:0]     mem_data;
        logic [REG_ADDR_W-1:0] wr_num;
        logic                  wr_en;
        logic [WB_SEL_W-1:0]   wb_sel;
    } slot_t;

    stage_state_e state;
    stage_state_e state_next;
    slot_t        main_slot;
    slot_t        main_next;
    slot_t        skid_slot;
    slot_t        skid_next;
    slot_t        in_slot;
    logic         in_fire;
    logic         out_fire;

    assign in_slot = '{npc:      in_npc,
                       alu_c:    in_alu_c,
                       mem_data: in_mem_data,
                       wr_num:   in_wr_num,
                       wr_en:    in_wr_en,
                       wb_sel:   in_wb_sel};

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State register; in_ready is a flop tracking "next state is not FULL".
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
        end
    end

    // Next-state logic; flush overrides any transfer.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (in_fire) state_next = BUSY;
            end
            BUSY: begin
                if (in_fire && !out_fire)      state_next = FULL;
                else if (!in_fire && out_fire) state_next = EMPTY;
            end
            FULL: begin
                if (out_fire) state_next = BUSY;
            end
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    // Slot update logic; vacated slots are zeroed so outputs stay deterministic.
    always_comb begin
        main_next = main_slot;
        skid_next = skid_slot;
        case (state)
            EMPTY: begin
                if (in_fire) main_next = in_slot;
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_next = in_slot;
                end else if (in_fire) begin
                    skid_next = in_slot;
                end else if (out_fire) begin
                    main_next = '0;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_next = skid_slot;
                    skid_next = '0;
                end
            end
            default: begin
                main_next = '0;
                skid_next = '0;
            end
        endcase
        if (flush) begin
            main_next = '0;
            skid_next = '0;
        end
    end

    // Payload registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_slot <= '0;
            skid_slot <= '0;
        end else begin
            main_slot <= main_next;
            skid_slot <= skid_next;
        end
    end

    // Back-pressure counter; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    wb_sel_mux #(
        .DATA_W   (DATA_W),
        .WB_SEL_W (WB_SEL_W)
    ) u_wb_sel_mux (
        .sel      (main_slot.wb_sel),
        .npc      (main_slot.npc),
        .alu_c    (main_slot.alu_c),
        .mem_data (main_slot.mem_data),
        .wb_data  (out_wb_data)
    );

    assign out_wr_num = main_slot.wr_num;
    assign out_wr_en  = main_slot.wr_en & out_valid;
    // Writes to r0 reach WB but must never be forwarded.
    assign fwd_valid  = out_valid & main_slot.wr_en & (main_slot.wr_num != '0);
    assign fwd_num    = main_slot.wr_num;
    assign fwd_data   = out_wb_data;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic (CNT_W=4 build) using a scoreboard queue.
module tb_mem_wb_elastic;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WB_SEL_W   = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_npc;
    logic [DATA_W-1:0]     in_alu_c;
    logic [DATA_W-1:0]     in_mem_data;
    logic [REG_ADDR_W-1:0] in_wr_num;
    logic                  in_wr_en;
    logic [WB_SEL_W-1:0]   in_wb_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_wr_num;
    logic                  out_wr_en;
    logic [DATA_W-1:0]     out_wb_data;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_num;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      stall_cnt;

    typedef struct {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] num;
        logic                  en;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_stall = 0;

    mem_wb_elastic #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .WB_SEL_W   (WB_SEL_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_npc      (in_npc),
        .in_alu_c    (in_alu_c),
        .in_mem_data (in_mem_data),
        .in_wr_num   (in_wr_num),
        .in_wr_en    (in_wr_en),
        .in_wb_sel   (in_wb_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wr_num  (out_wr_num),
        .out_wr_en   (out_wr_en),
        .out_wb_data (out_wb_data),
        .fwd_valid   (fwd_valid),
        .fwd_num     (fwd_num),
        .fwd_data    (fwd_data),
        .stall_cnt   (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_wb(input logic [1:0] sel,
                                                   input logic [DATA_W-1:0] npc,
                                                   input logic [DATA_W-1:0] alu,
                                                   input logic [DATA_W-1:0] mem);
        case (sel)
            2'b00:   return alu;
            2'b01:   return mem;
            2'b10:   return npc;
            default: return '0;
        endcase
    endfunction

    // Scoreboard monitor: inputs are stable at the falling edge, so transfers
    // that happen on the next rising edge are predicted here.
    always @(negedge clock) begin
        logic full_m;
        exp_t e;
        if (reset) begin
            sb.delete();
            exp_stall = 0;
        end else begin
            full_m = (sb.size() == 2);
            check("in_ready", 32'(in_ready), 32'(!full_m));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("stall_cnt", 32'(stall_cnt), exp_stall);
            if (sb.size() != 0) begin
                e = sb[0];
                check("wb_data", out_wb_data, e.data);
                check("wr_num", 32'(out_wr_num), 32'(e.num));
                check("wr_en", 32'(out_wr_en), 32'(e.en));
                check("fwd_valid", 32'(fwd_valid), 32'(e.en && (e.num != 0)));
                check("fwd_num", 32'(fwd_num), 32'(e.num));
                check("fwd_data", fwd_data, e.data);
            end else begin
                check("idle_wr_en", 32'(out_wr_en), 32'(0));
                check("idle_fwd", 32'(fwd_valid), 32'(0));
                check("idle_wb_data", out_wb_data, 32'(0));
            end
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && full_m && exp_stall != CNT_MAX) exp_stall++;
            if (flush) begin
                sb.delete();
            end else if (in_valid && !full_m) begin
                e.data = model_wb(in_wb_sel, in_npc, in_alu_c, in_mem_data);
                e.num  = in_wr_num;
                e.en   = in_wr_en;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] sel, input logic [31:0] npc,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] num, input logic en);
        in_valid    = v;
        in_wb_sel   = sel;
        in_npc      = npc;
        in_alu_c    = alu;
        in_mem_data = mem;
        in_wr_num   = num;
        in_wr_en    = en;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_stall", 32'(stall_cnt), 32'(0));

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 2'b00, 32'h100 + 32'(i), 32'(i * 16), 32'h5a5a_0000, 5'(i), 1'b1);
            step();
            check("stream_data", out_wb_data, 32'(i * 16));
        end
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        check("stream_stall", 32'(stall_cnt), 32'(0));

        // Back-pressure fills the skid slot; release drains in order.
        out_ready = 1'b0;
        set_in(1'b1, 2'b01, 32'h4, 32'h1, 32'hDEAD_BEEF, 5'd8, 1'b1);
        step();
        set_in(1'b1, 2'b00, 32'h8, 32'hB0B, 32'h2, 5'd9, 1'b1);
        step();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_head", out_wb_data, 32'hDEAD_BEEF);
        step();
        step();
        out_ready = 1'b1;
        step();
        check("drain_b", out_wb_data, 32'hB0B);
        step();
        step();

        // Stall counting while FULL, then flush.
        out_ready = 1'b0;
        set_in(1'b1, 2'b01, 32'h4, 32'h1, 32'hDEAD_BEEF, 5'd8, 1'b1);
        step();
        set_in(1'b1, 2'b00, 32'h8, 32'hB0B, 32'h2, 5'd9, 1'b1);
        step();
        set_in(1'b1, 2'b00, 32'hC, 32'hC0C, 32'h3, 5'd10, 1'b1);
        repeat (5) step();
        check("stall5", 32'(stall_cnt), 32'(5));
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_stall", 32'(stall_cnt), 32'(5));
        check("flush_out_valid", 32'(out_valid), 32'(0));
        check("flush_in_ready", 32'(in_ready), 32'(1));

        // Flush while FULL with a new entry offered: nothing survives.
        set_in(1'b1, 2'b01, 32'h4, 32'h1, 32'hDEAD_BEEF, 5'd8, 1'b1);
        step();
        set_in(1'b1, 2'b00, 32'h8, 32'hB0B, 32'h2, 5'd9, 1'b1);
        step();
        set_in(1'b1, 2'b00, 32'hC, 32'hC0C, 32'h3, 5'd10, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        out_ready = 1'b1;
        repeat (3) step();
        check("flushc_out_valid", 32'(out_valid), 32'(0));

        // Forwarding tap and reserved selector.
        out_ready = 1'b0;
        set_in(1'b1, 2'b10, 32'h0040_0008, 32'h11, 32'h22, 5'd31, 1'b1);
        step();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        check("fwd31_valid", 32'(fwd_valid), 32'(1));
        check("fwd31_num", 32'(fwd_num), 32'(31));
        check("fwd31_data", fwd_data, 32'h0040_0008);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_in(1'b1, 2'b10, 32'h0040_0008, 32'h11, 32'h22, 5'd0, 1'b1);
        step();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        check("r0_fwd_valid", 32'(fwd_valid), 32'(0));
        check("r0_wr_en", 32'(out_wr_en), 32'(1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_in(1'b1, 2'b11, 32'h1234, 32'h5678, 32'h9ABC, 5'd3, 1'b1);
        step();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        check("sel11_data", out_wb_data, 32'h0);
        out_ready = 1'b1;
        step();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);

        // Saturation, then reset mid-transfer.
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, 32'h0, 32'h77, 32'h0, 5'd4, 1'b1);
        repeat ((1 << CNT_W) + 3) step();
        check("stall_sat", 32'(stall_cnt), CNT_MAX);
        reset = 1'b1;
        step();
        check("reset_stall", 32'(stall_cnt), 32'(0));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        reset = 1'b0;
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0);
        step();
        check("post_reset_in_ready", 32'(in_ready), 32'(1));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_elastic.md
Name: mem_wb_elastic

Overview:
Parametrised MEM/WB pipeline stage for the 5-stage core. It replaces the fixed always-load register with an elastic valid/ready stage. The stage adds a one-entry skid buffer, synchronous flush, a write-back value select and a forwarding tap for the hazard unit. It sits between the data-memory stage and the register-file write port, and counts back-pressure cycles for performance analysis.

Parameters:
DATA_W, 32, width of npc / alu result / memory data / write-back value
REG_ADDR_W, 5, register-number width
WB_SEL_W, 2, write-back source selector width (fixed encoding, see Behaviour)
CNT_W, 16, stall-counter width

Ports:
clock  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  stage can accept (registered)
in_npc  in  DATA_W  PC+4 of instruction
in_alu_c  in  DATA_W  ALU result
in_mem_data  in  DATA_W  load data
in_wr_num  in  REG_ADDR_W  destination register
in_wr_en  in  1  register write enable
in_wb_sel  in  WB_SEL_W  write-back source select
out_valid  out  1  head entry valid
out_ready  in  1  WB stage consumes head
out_wr_num  out  REG_ADDR_W  head destination
out_wr_en  out  1  head wr_en AND out_valid
out_wb_data  out  DATA_W  selected write-back value of head
fwd_valid  out  1  head forwards: out_valid & wr_en & wr_num!=0
fwd_num  out  REG_ADDR_W  = out_wr_num
fwd_data  out  DATA_W  = out_wb_data
stall_cnt  out  CNT_W  saturating count of cycles with in_valid & !in_ready

Behaviour:
- Storage: main slot (drives outputs) and skid slot. Each slot holds npc, alu_c, mem_data, wr_num, wr_en, wb_sel.
- States: EMPTY (no entries), BUSY (main only), FULL (main+skid). in_ready = (state != FULL), registered from state.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; out_valid = (state != EMPTY).
- EMPTY: in_fire -> main<=in, BUSY.
- BUSY: in_fire & out_fire -> main<=in, stay BUSY. in_fire only -> skid<=in, FULL. out_fire only -> EMPTY. Neither -> hold.
- FULL: no input accepted. out_fire -> main<=skid, BUSY. Otherwise hold.
- Latency 1 cycle from accept to out_valid when not back-pressured. Full throughput, one entry per cycle, with out_ready held high.
- Ordering is strictly FIFO. The head is never overwritten while out_valid & !out_ready.
- wb_sel encoding: 00 alu_c, 01 mem_data, 10 npc (jal), 11 reserved -> out_wb_data = 0.
- out_wb_data is combinational from the main slot only.
- Payload of an empty slot is held at zero, so outputs are deterministic. out_wr_en and fwd_valid are 0 whenever out_valid=0.
- Flush: next cycle state EMPTY, both slots zeroed, in_ready=1. An entry offered in the flush cycle is dropped. An out_fire in the flush cycle is still consumed by WB (the downstream WB stage already sampled it).
- Reset: state EMPTY, all slots zero, stall_cnt=0, in_ready=1 after the reset cycle. Reset has priority over flush. Asserting reset mid-transfer discards all entries.
- stall_cnt increments when in_valid & !in_ready. It saturates at 2^CNT_W-1, is unaffected by flush and is cleared only by reset.
- wr_num=0 with wr_en=1 is still passed to WB, which ignores it. It never raises fwd_valid.

Decomposition:
- Shared package pipe_pkg: WB_SEL_ALU/WB_SEL_MEM/WB_SEL_NPC constants and the state encoding EMPTY/BUSY/FULL. The package also holds the slot payload struct, which the other stage registers will reuse.
- One natural sub-module: wb_sel_mux, the combinational DATA_W 4:1 selector. It is instantiated once on the main slot.

Test Plan:
- Reset, then stream 4 entries with out_ready=1 and wb_sel=00, alu_c=0x10,0x20,0x30,0x40 -> out_wb_data shows the same sequence one cycle later. in_ready is never 0 and stall_cnt stays 0.
- Entry A (wb_sel=01, mem_data=0xDEADBEEF, wr_num=8) held with out_ready=0, then B accepted -> state FULL, in_ready=0. Release out_ready -> A then B in order, with no duplicate and no loss.
- Hold out_ready=0 with in_valid=1 for 5 cycles after FULL -> stall_cnt=5. Flush -> stall_cnt stays 5, out_valid=0, in_ready=1 next cycle.
- Flush asserted while FULL with in_valid=1 carrying C -> C is never presented; both A and B are discarded.
- wb_sel=10, npc=0x0040_0008, wr_num=31, wr_en=1 -> fwd_valid=1, fwd_num=31, fwd_data=0x0040_0008. The same entry with wr_num=0 -> fwd_valid=0 and out_wr_en=1. wb_sel=11 -> out_wb_data=0.
- Drive in_valid=1 and out_ready=0 for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cnt saturates at 15. Reset -> stall_cnt=0 and out_valid=0.
